cim_stack_result_collector: RTL

// Downstream of the multi-stack CIM compute array: captures the per-stack stage-4 results, accumulates
// NUM_PASSES consecutive result vectors per stack (partial sums across weight tiles), then drains the
// NUM_STACKS accumulators one word per beat over a valid/ready stream toward the host/AXI side.

---
 rtl/cim_stack_result_collector_if.sv | 27 ++
 rtl/cim_stack_result_collector.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cim_stack_result_collector_if.sv
// Stream bundle for the CIM stack result collector: result-vector input and drained-word output.
interface cim_stack_result_collector_if #(
    parameter int unsigned NUM_STACKS = 8,
    parameter int unsigned IN_WIDTH   = 22,
    parameter int unsigned ACC_WIDTH  = 32
);
    localparam int unsigned IDX_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;

    logic                                in_valid;
    logic                                in_ready;
    logic [NUM_STACKS-1:0][IN_WIDTH-1:0] in_data;
    logic                                out_valid;
    logic                                out_ready;
    logic [ACC_WIDTH-1:0]                out_data;
    logic [IDX_W-1:0]                    out_idx;
    logic                                out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/cim_stack_result_collector.sv
// Accumulates NUM_PASSES per-stack result vectors, then drains one accumulator per beat.
// Optional clamping adds with sticky sat_flag when CIM_COLLECT_SATURATE_EN is defined.
module cim_stack_result_collector #(
    parameter int unsigned NUM_STACKS = 8,
    parameter int unsigned IN_WIDTH   = 22,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned NUM_PASSES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    cim_stack_result_collector_if.slave       bus,
    input  logic                              flush,
    output logic [$clog2(NUM_PASSES+1)-1:0]   pass_cnt,
    output logic                              busy,
    output logic                              sat_flag
);
    localparam int unsigned IDX_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
    localparam int unsigned PC_W  = $clog2(NUM_PASSES + 1);

    localparam logic [0:0] StAccum = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic [PC_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0] acc_q [NUM_STACKS];
    logic signed [ACC_WIDTH-1:0] acc_d [NUM_STACKS];
    logic signed [ACC_WIDTH-1:0] ext   [NUM_STACKS];
    logic signed [ACC_WIDTH-1:0] sum   [NUM_STACKS];
    logic                        accept, beat, last_idx, any_clamp;

    assign accept   = bus.in_valid && (state_q == StAccum) && !flush;
    assign beat     = (state_q == StDrain) && bus.out_ready;
    assign last_idx = (idx_q == IDX_W'(NUM_STACKS - 1));

`ifdef CIM_COLLECT_SATURATE_EN
    logic                    sat_q, sat_d;
    logic signed [ACC_WIDTH:0] wide [NUM_STACKS];
    logic [NUM_STACKS-1:0]   clamp;

    // One guard bit exposes overflow; its disagreement with the MSB picks the clamp direction.
    always_comb begin
        for (int s = 0; s < NUM_STACKS; s++) begin
            ext[s]   = ACC_WIDTH'($signed(bus.in_data[s]));
            wide[s]  = {acc_q[s][ACC_WIDTH-1], acc_q[s]} + {ext[s][ACC_WIDTH-1], ext[s]};
            clamp[s] = wide[s][ACC_WIDTH] ^ wide[s][ACC_WIDTH-1];
            if (!clamp[s]) begin
                sum[s] = wide[s][ACC_WIDTH-1:0];
            end else if (wide[s][ACC_WIDTH]) begin
                sum[s] = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                sum[s] = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end
    end

    assign any_clamp = |clamp;
    assign sat_flag  = sat_q;
`else
    always_comb begin
        for (int s = 0; s < NUM_STACKS; s++) begin
            ext[s] = ACC_WIDTH'($signed(bus.in_data[s]));
            sum[s] = acc_q[s] + ext[s];
        end
    end

    assign any_clamp = 1'b0;
    assign sat_flag  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        for (int s = 0; s < NUM_STACKS; s++) acc_d[s] = acc_q[s];
`ifdef CIM_COLLECT_SATURATE_EN
        sat_d = sat_q;
`endif
        if (flush) begin
            state_d = StAccum;
            cnt_d   = '0;
            idx_d   = '0;
            for (int s = 0; s < NUM_STACKS; s++) acc_d[s] = '0;
`ifdef CIM_COLLECT_SATURATE_EN
            sat_d = 1'b0;
`endif
        end else begin
            case (state_q)
                StAccum: begin
                    if (accept) begin
                        for (int s = 0; s < NUM_STACKS; s++) acc_d[s] = sum[s];
                        cnt_d = cnt_q + PC_W'(1);
`ifdef CIM_COLLECT_SATURATE_EN
                        sat_d = sat_q | any_clamp;
`endif
                        if (cnt_q == PC_W'(NUM_PASSES - 1)) begin
                            state_d = StDrain;
                            idx_d   = '0;
                        end
                    end
                end
                StDrain: begin
                    if (beat) begin
                        if (last_idx) begin
                            state_d = StAccum;
                            cnt_d   = '0;
                            idx_d   = '0;
                            for (int s = 0; s < NUM_STACKS; s++) acc_d[s] = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = StAccum;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            idx_q   <= '0;
            for (int s = 0; s < NUM_STACKS; s++) acc_q[s] <= '0;
`ifdef CIM_COLLECT_SATURATE_EN
            sat_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            for (int s = 0; s < NUM_STACKS; s++) acc_q[s] <= acc_d[s];
`ifdef CIM_COLLECT_SATURATE_EN
            sat_q <= sat_d;
`endif
        end
    end

    // All outputs come straight from state registers; no input-to-output path.
    assign bus.in_ready  = (state_q == StAccum);
    assign bus.out_valid = (state_q == StDrain);
    assign bus.out_data  = acc_q[idx_q];
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (state_q == StDrain) && last_idx;
    assign busy          = (state_q == StDrain);
    assign pass_cnt      = cnt_q;

    logic unused_any_clamp;
    assign unused_any_clamp = any_clamp;
endmodule
